pipeline_ctrl: RTL and testbench

Stage sequencer for the 4-stage integer pipeline (I = fetch/decode, X = execute, M = memory, R = retire). It tracks per-stage valid bits and assigns per-instruction sequence IDs. It detects load-use hazards and stalls, and flushes wrong-path work on taken branches/jumps. It also produces the X-stage operand forwarding selects. Its `inst_v_*` and `c*` outputs drive the trace/pipeline-visualisation logger directly.

---
 rtl/pipeline_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Stage sequencer for the 4-stage integer pipeline (I fetch/decode, X execute,
// M memory, R retire). Tracks a valid bit and a sequence ID per stage, stalls
// on load-use hazards, flushes wrong-path work on PC redirects and produces the
// X-stage operand forwarding selects. The inst_v_* and c* outputs feed the
// pipeline trace logger directly.
//
// Ports
//   clk                     clock, all state updates on the rising edge
//   reset                   synchronous, active-low
//   fetch_valid             instruction memory presents an instruction
//   i_rs1/i_rs2, i_use1/2   sources of the I instruction and whether read
//   x_rs1/x_rs2             sources of the X instruction
//   x_rd, x_we, x_is_load   destination / write enable / load flag of X
//   pcv                     X instruction redirects the PC
//   m_rd, m_we              destination / write enable of M
//   r_rd, r_we              destination / write enable of R
//   inst_v_i/x/m/r          per-stage valid
//   ci/cx/cm/cr             per-stage sequence ID (don't-care when invalid)
//   stall                   hold PC and I register this cycle
//   flush                   kill the I instruction and the incoming fetch
//   fwd1/fwd2               X operand source: 0 regfile, 1 M, 2 R writeback
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int ID_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    input  logic            i_use1,
    input  logic            i_use2,
    input  logic [4:0]      x_rs1,
    input  logic [4:0]      x_rs2,
    input  logic [4:0]      x_rd,
    input  logic            x_we,
    input  logic            x_is_load,
    input  logic            pcv,
    input  logic [4:0]      m_rd,
    input  logic            m_we,
    input  logic [4:0]      r_rd,
    input  logic            r_we,
    output logic            inst_v_i,
    output logic            inst_v_x,
    output logic            inst_v_m,
    output logic            inst_v_r,
    output logic [ID_W-1:0] ci,
    output logic [ID_W-1:0] cx,
    output logic [ID_W-1:0] cm,
    output logic [ID_W-1:0] cr,
    output logic            stall,
    output logic            flush,
    output logic [1:0]      fwd1,
    output logic [1:0]      fwd2
);

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_R  = 2'd2;

    logic [ID_W-1:0] next_id;
    logic            load_use;
    logic            advance_i;
    logic            consume_id;
    logic            m_src_ok;
    logic            r_src_ok;

    // ------------------------------------------------------------------
    // Hazard detection. Flush wins over stall: the stalled consumer is on
    // the wrong path anyway once X redirects.
    // ------------------------------------------------------------------
    assign flush = inst_v_x & pcv;

    assign load_use = inst_v_i & inst_v_x & x_is_load & x_we & (x_rd != 5'd0)
                    & ((i_use1 & (i_rs1 == x_rd)) | (i_use2 & (i_rs2 == x_rd)));

    assign stall = load_use & ~flush;

    // I instruction moves on to X only when neither held nor killed.
    assign advance_i = inst_v_i & ~stall & ~flush;

    // A fetch consumes an ID whenever the PC is not held, even if the
    // fetched instruction is immediately killed by a flush.
    assign consume_id = fetch_valid & ~stall;

    // ------------------------------------------------------------------
    // I stage and ID allocator
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            inst_v_i <= 1'b0;
            ci       <= '0;
            next_id  <= '0;
        end else begin
            if (flush) begin
                inst_v_i <= 1'b0;
            end else if (!stall) begin
                inst_v_i <= fetch_valid;
                if (fetch_valid) begin
                    ci <= next_id;
                end
            end
            if (consume_id) begin
                next_id <= next_id + ID_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // X stage: a stall leaves a bubble behind the held I instruction.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            inst_v_x <= 1'b0;
            cx       <= '0;
        end else begin
            inst_v_x <= advance_i;
            if (advance_i) begin
                cx <= ci;
            end
        end
    end

    // ------------------------------------------------------------------
    // M and R stages never stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            inst_v_m <= 1'b0;
            inst_v_r <= 1'b0;
            cm       <= '0;
            cr       <= '0;
        end else begin
            inst_v_m <= inst_v_x;
            inst_v_r <= inst_v_m;
            cm       <= cx;
            cr       <= cm;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding. M is the younger producer so it takes priority.
    // x0 is never forwarded since it always reads as zero from the regfile.
    // ------------------------------------------------------------------
    assign m_src_ok = inst_v_m & m_we & (m_rd != 5'd0);
    assign r_src_ok = inst_v_r & r_we & (r_rd != 5'd0);

    always_comb begin
        fwd1 = FWD_RF;
        if (m_src_ok && (m_rd == x_rs1)) begin
            fwd1 = FWD_M;
        end else if (r_src_ok && (r_rd == x_rs1)) begin
            fwd1 = FWD_R;
        end
    end

    always_comb begin
        fwd2 = FWD_RF;
        if (m_src_ok && (m_rd == x_rs2)) begin
            fwd2 = FWD_M;
        end else if (r_src_ok && (r_rd == x_rs2)) begin
            fwd2 = FWD_R;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic        clk;
    logic        reset;
    logic        fetch_valid;
    logic [4:0]  i_rs1, i_rs2;
    logic        i_use1, i_use2;
    logic [4:0]  x_rs1, x_rs2, x_rd;
    logic        x_we, x_is_load, pcv;
    logic [4:0]  m_rd, r_rd;
    logic        m_we, r_we;

    logic        inst_v_i, inst_v_x, inst_v_m, inst_v_r;
    logic [31:0] ci, cx, cm, cr;
    logic        stall, flush;
    logic [1:0]  fwd1, fwd2;

    logic        w_inst_v_i, w_inst_v_x, w_inst_v_m, w_inst_v_r;
    logic [3:0]  w_ci, w_cx, w_cm, w_cr;
    logic        w_stall, w_flush;
    logic [1:0]  w_fwd1, w_fwd2;

    pipeline_ctrl #(.ID_W(32)) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_use1(i_use1), .i_use2(i_use2),
        .x_rs1(x_rs1), .x_rs2(x_rs2), .x_rd(x_rd), .x_we(x_we),
        .x_is_load(x_is_load), .pcv(pcv),
        .m_rd(m_rd), .m_we(m_we), .r_rd(r_rd), .r_we(r_we),
        .inst_v_i(inst_v_i), .inst_v_x(inst_v_x), .inst_v_m(inst_v_m), .inst_v_r(inst_v_r),
        .ci(ci), .cx(cx), .cm(cm), .cr(cr),
        .stall(stall), .flush(flush), .fwd1(fwd1), .fwd2(fwd2)
    );

    // Narrow-ID copy so the modulo wrap of the allocator is reachable quickly.
    pipeline_ctrl #(.ID_W(4)) dut_w (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_use1(i_use1), .i_use2(i_use2),
        .x_rs1(x_rs1), .x_rs2(x_rs2), .x_rd(x_rd), .x_we(x_we),
        .x_is_load(x_is_load), .pcv(pcv),
        .m_rd(m_rd), .m_we(m_we), .r_rd(r_rd), .r_we(r_we),
        .inst_v_i(w_inst_v_i), .inst_v_x(w_inst_v_x), .inst_v_m(w_inst_v_m), .inst_v_r(w_inst_v_r),
        .ci(w_ci), .cx(w_cx), .cm(w_cm), .cr(w_cr),
        .stall(w_stall), .flush(w_flush), .fwd1(w_fwd1), .fwd2(w_fwd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model of the stage valids and the ID allocator.
    logic        mv_i = 1'b0, mv_x = 1'b0, mv_m = 1'b0, mv_r = 1'b0;
    logic [31:0] mc_i = 32'd0;
    logic [31:0] m_nid = 32'd0;
    logic [31:0] sb[$];

    logic        chk_fwd = 1'b0;
    logic [1:0]  exp_f1 = 2'd0, exp_f2 = 2'd0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] mrd;
        logic       mwe;
        logic [4:0] rrd;
        logic       rwe;
        logic [1:0] f1;
        logic [1:0] f2;
    } fvec_t;

    fvec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_hz();
        pcv = 1'b0; x_is_load = 1'b0; x_we = 1'b0; x_rd = 5'd0;
        i_use1 = 1'b0; i_use2 = 1'b0; i_rs1 = 5'd0; i_rs2 = 5'd0;
        x_rs1 = 5'd0; x_rs2 = 5'd0;
        m_rd = 5'd0; m_we = 1'b0; r_rd = 5'd0; r_we = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; checks combinational
    // outputs, advances one clock, then checks registered state.
    task automatic cycle();
        logic e_st, e_fl, rv;
        logic [31:0] e_id;
        #1;
        e_fl = mv_x & pcv;
        e_st = mv_i & mv_x & x_is_load & x_we & (x_rd != 5'd0)
             & ((i_use1 & (i_rs1 == x_rd)) | (i_use2 & (i_rs2 == x_rd))) & ~e_fl;
        chk("stall", 32'(stall), 32'(e_st));
        chk("flush", 32'(flush), 32'(e_fl));
        if (chk_fwd) begin
            chk("fwd1", 32'(fwd1), 32'(exp_f1));
            chk("fwd2", 32'(fwd2), 32'(exp_f2));
            chk_fwd = 1'b0;
        end
        rv = reset;
        @(posedge clk);
        if (!rv) begin
            mv_i = 1'b0; mv_x = 1'b0; mv_m = 1'b0; mv_r = 1'b0;
            mc_i = 32'd0; m_nid = 32'd0;
            sb.delete();
        end else begin
            mv_r = mv_m;
            mv_m = mv_x;
            mv_x = mv_i & ~e_st & ~e_fl;
            if (e_fl) begin
                if (mv_i) sb.delete(sb.size() - 1);
                mv_i = 1'b0;
                if (fetch_valid) m_nid = m_nid + 32'd1;
            end else if (!e_st) begin
                mv_i = fetch_valid;
                if (fetch_valid) begin
                    mc_i = m_nid;
                    sb.push_back(m_nid);
                    m_nid = m_nid + 32'd1;
                end
            end
        end
        #1;
        chk("valids", 32'({inst_v_i, inst_v_x, inst_v_m, inst_v_r}),
                      32'({mv_i, mv_x, mv_m, mv_r}));
        if (mv_i) chk("ci", ci, mc_i);
        if (mv_r) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: retire seen with cr=%0h, nothing expected", cr);
            end else begin
                e_id = sb.pop_front();
                chk("cr", cr, e_id);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        //           rs1    rs2    mrd    mwe   rrd    rwe   f1    f2
        tbl[0] = '{5'd3,  5'd4,  5'd3,  1'b1, 5'd4,  1'b1, 2'd1, 2'd2};
        tbl[1] = '{5'd3,  5'd9,  5'd3,  1'b1, 5'd3,  1'b1, 2'd1, 2'd0};
        tbl[2] = '{5'd3,  5'd9,  5'd3,  1'b0, 5'd3,  1'b1, 2'd2, 2'd0};
        tbl[3] = '{5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 2'd0, 2'd0};
        tbl[4] = '{5'd7,  5'd7,  5'd7,  1'b0, 5'd7,  1'b0, 2'd0, 2'd0};
        tbl[5] = '{5'd31, 5'd30, 5'd30, 1'b1, 5'd31, 1'b1, 2'd2, 2'd1};
        tbl[6] = '{5'd1,  5'd2,  5'd2,  1'b1, 5'd2,  1'b1, 2'd0, 2'd1};
        tbl[7] = '{5'd5,  5'd6,  5'd9,  1'b1, 5'd10, 1'b1, 2'd0, 2'd0};

        reset = 1'b0;
        fetch_valid = 1'b1;
        clear_hz();
        @(posedge clk);          // first reset edge: prior state is unknown
        @(negedge clk);

        // Reset held with every hazard qualifier asserted: nothing may fire.
        pcv = 1'b1; x_is_load = 1'b1; x_we = 1'b1; x_rd = 5'd5;
        i_use1 = 1'b1; i_rs1 = 5'd5;
        x_rs1 = 5'd3; m_rd = 5'd3; m_we = 1'b1; r_rd = 5'd3; r_we = 1'b1;
        chk_fwd = 1'b1; exp_f1 = 2'd0; exp_f2 = 2'd0;
        cycle();
        chk("rst_ids", {ci[7:0], cx[7:0], cm[7:0], cr[7:0]}, 32'd0);
        chk("rst_ids_hi", ci | cx | cm | cr, 32'd0);
        chk("rst_w", 32'({w_inst_v_i, w_inst_v_x, w_inst_v_m, w_inst_v_r, w_stall, w_flush,
                          w_fwd1, w_fwd2, w_ci, w_cx, w_cm, w_cr}), 32'd0);
        clear_hz();
        reset = 1'b1;

        // Hazard-free stream.
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (i == 0) begin
                chk("first_vi", 32'(inst_v_i), 32'd1);
                chk("first_ci", ci, 32'd0);
            end
            if (i == 3) chk("first_cr", cr, 32'd0);
        end

        // Forwarding vectors with a full pipeline.
        for (int k = 0; k < 8; k++) begin
            x_rs1 = tbl[k].rs1; x_rs2 = tbl[k].rs2;
            m_rd = tbl[k].mrd;  m_we = tbl[k].mwe;
            r_rd = tbl[k].rrd;  r_we = tbl[k].rwe;
            chk_fwd = 1'b1; exp_f1 = tbl[k].f1; exp_f2 = tbl[k].f2;
            cycle();
        end
        clear_hz();

        // Load x5 in X, I reads x5 via rs2.
        x_is_load = 1'b1; x_we = 1'b1; x_rd = 5'd5; i_use2 = 1'b1; i_rs2 = 5'd5;
        #1 chk("lu_stall", 32'(stall), 32'd1);
        cycle();
        chk("lu_bubble", 32'(inst_v_x), 32'd0);
        cycle();                 // X is a bubble now: stall must not repeat
        clear_hz();
        x_rs2 = 5'd5; r_rd = 5'd5; r_we = 1'b1; m_rd = 5'd5; m_we = 1'b1;
        chk_fwd = 1'b1; exp_f1 = 2'd0; exp_f2 = 2'd2;
        #1 chk("lu_consumer_vx", 32'({inst_v_x, inst_v_m, inst_v_r}), 32'b101);
        cycle();
        clear_hz();

        // Load to x0 never stalls.
        x_is_load = 1'b1; x_we = 1'b1; x_rd = 5'd0; i_use2 = 1'b1; i_rs2 = 5'd0;
        #1 chk("lu_rd0", 32'(stall), 32'd0);
        cycle();
        clear_hz();
        cycle();

        // Taken branch with ci = 7.
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("fl_pre", {ci[30:0], inst_v_x}, {31'd7, 1'b1});
        pcv = 1'b1;
        #1 chk("fl_flush", 32'(flush), 32'd1);
        cycle();
        pcv = 1'b0;
        chk("fl_kill", 32'(inst_v_i), 32'd0);
        cycle();
        chk("fl_next", ci, 32'd9);
        cycle();
        chk("fl_cx", cx, 32'd9);

        // Redirect and load-use hazard in the same cycle.
        pcv = 1'b1; x_is_load = 1'b1; x_we = 1'b1; x_rd = 5'd5;
        i_use1 = 1'b1; i_rs1 = 5'd5;
        #1 chk("both", 32'({flush, stall}), 32'b10);
        cycle();
        clear_hz();
        for (int i = 0; i < 4; i++) cycle();

        // Reset in mid-stream.
        reset = 1'b0;
        cycle();
        chk("mid_cr", cr, 32'd0);
        reset = 1'b1;
        cycle();
        chk("mid_ci", ci, 32'd0);

        // Narrow allocator wraps 0xF -> 0.
        for (int k = 1; k <= 17; k++) begin
            cycle();
            chk("wrap_ci", 32'(w_ci), 32'(k % 16));
        end

        // Drain with no fetches: IDs are not consumed and everything retires.
        fetch_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        fetch_valid = 1'b1;
        cycle();
        chk("after_idle_ci", ci, 32'd18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
